// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared state encoding, opcodes and ALU op codes for the multicycle controller
package riscv_ctrl_pkg;
  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_e;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts memory wait cycles and flags when MEM_TIMEOUT has been reached
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int W = $clog2(MEM_TIMEOUT + 1);
  logic [W-1:0] cnt_q;
  assign expired_o = cnt_q == W'(MEM_TIMEOUT);
  always_ff @(posedge clk) begin
    if (clear_i) cnt_q <= '0;
    else if (enable_i && !expired_o) cnt_q <= cnt_q + W'(1);
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multi-cycle sequencer with memory timeout, illegal-opcode trap and retire counter
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem2reg,
  output logic             illegal_op,
  output logic             bus_error,
  output logic [CNT_W-1:0] instr_retired
);
  state_e state_q, state_d;
  logic [6:0] opcode_q;
  logic illegal_q, bus_err_q, in_acc, expired, legal, timeout, retire, run;
  logic is_r, is_lw, is_sw, alu_stage;
  logic [CNT_W-1:0] cnt_q;
  assign run = !reset;
  assign in_acc = state_q == S_FETCH || state_q == S_MEM;
  assign legal = opcode inside {OP_R, OP_I, OP_LW, OP_SW};
  assign timeout = in_acc && !mem_ready && expired;
  assign is_r = opcode_q == OP_R;
  assign is_lw = opcode_q == OP_LW;
  assign is_sw = opcode_q == OP_SW;
  assign alu_stage = state_q == S_EXECUTE || state_q == S_MEM;
  assign retire = state_q == S_WB || (state_q == S_MEM && is_sw && mem_ready);
  // A completed access leaves FETCH/MEM, so mem_ready doubles as the clear on exit
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk      (clk),
    .clear_i  (reset || !in_acc || mem_ready),
    .enable_i (in_acc && !mem_ready),
    .expired_o(expired)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   state_d = mem_ready ? S_DECODE : (expired ? S_TRAP : S_FETCH);
      S_DECODE:  state_d = legal ? S_EXECUTE : S_TRAP;
      S_EXECUTE: state_d = (is_lw || is_sw) ? S_MEM : S_WB;
      S_MEM:     state_d = mem_ready ? (is_sw ? S_FETCH : S_WB) : (expired ? S_TRAP : S_MEM);
      S_WB:      state_d = S_FETCH;
      default:   state_d = S_TRAP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) opcode_q <= opcode;
      if (state_q == S_DECODE && !legal) illegal_q <= 1'b1;
      if (timeout) bus_err_q <= 1'b1;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end
  assign pc_write      = run && state_q == S_FETCH && mem_ready;
  assign ir_write      = pc_write;
  assign mem_read      = run && (state_q == S_FETCH || (state_q == S_MEM && is_lw));
  assign mem_write     = run && state_q == S_MEM && is_sw;
  assign i_or_d        = run && state_q == S_MEM;
  assign alu_src       = run && alu_stage && !is_r;
  assign alu_op        = (run && alu_stage && !(is_lw || is_sw)) ? ALU_FUNCT : ALU_ADD;
  assign reg_write     = run && state_q == S_WB;
  assign mem2reg       = reg_write && is_lw;
  assign illegal_op    = run && illegal_q;
  assign bus_error     = run && bus_err_q;
  assign instr_retired = run ? cnt_q : '0;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: random instruction streams checked cycle-by-cycle against a latency-rule reference
module tb_multicycle_controller;
  import riscv_ctrl_pkg::*;
  localparam int TO = 4;
  localparam int CW = 4;
  logic clk = 1'b0, reset = 1'b1, mem_ready = 1'b0;
  logic [6:0] opcode = '0;
  logic pc_write, ir_write, mem_read, mem_write, i_or_d, alu_src, reg_write, mem2reg, illegal_op, bus_error;
  logic [1:0] alu_op;
  logic [CW-1:0] instr_retired;
  multicycle_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .alu_src(alu_src), .alu_op(alu_op), .reg_write(reg_write),
    .mem2reg(mem2reg), .illegal_op(illegal_op), .bus_error(bus_error), .instr_retired(instr_retired)
  );
  always #5 clk = ~clk;
  typedef struct {string tag; logic [15:0] v;} item_t;
  item_t q[$];
  item_t it;
  logic [15:0] act;
  int n_chk = 0, n_fail = 0;
  int m_ret = 0;
  bit m_ill = 1'b0, m_bus = 1'b0;
  logic [6:0] legal_ops[4] = '{OP_R, OP_I, OP_LW, OP_SW};
  // Expected vector: {pc,ir,rd,wr,iod,src,aop[1:0],rw,m2r,ill,bus,retired[3:0]}
  function automatic logic [15:0] mk(bit pc, bit ir, bit rd, bit wr, bit iod, bit src, logic [1:0] aop, bit rw, bit m2r);
    return {pc, ir, rd, wr, iod, src, aop, rw, m2r, m_ill, m_bus, 4'(m_ret)};
  endfunction
  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction
  always @(negedge clk) begin
    if (q.size() > 0) begin
      it = q.pop_front();
      act = {pc_write, ir_write, mem_read, mem_write, i_or_d, alu_src, alu_op, reg_write, mem2reg,
             illegal_op, bus_error, instr_retired};
      n_chk++;
      if (act !== it.v) begin
        n_fail++;
        $display("FAIL %s @%0t: got %b expected %b", it.tag, $time, act, it.v);
      end
    end
  end
  task automatic cyc(string tag, logic [6:0] op, bit rdy, logic [15:0] e);
    q.push_back('{tag, e});
    opcode = op;
    mem_ready = rdy;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(int n);
    reset = 1'b1;
    repeat (n) cyc("reset", rop(), 1'b1, 16'h0);
    reset = 1'b0;
    m_ret = 0;
    m_ill = 1'b0;
    m_bus = 1'b0;
  endtask
  task automatic trap_idle(int n);
    repeat (n) cyc("trap", rop(), 1'($urandom), mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
  endtask
  task automatic access(string tag, int waits, logic [15:0] base, logic [15:0] done, output bit to);
    to = 1'b0;
    for (int i = 0; i <= TO; i++) begin
      if (i == waits) begin
        cyc(tag, rop(), 1'b1, done);
        return;
      end
      cyc(tag, rop(), 1'b0, base);
    end
    to = 1'b1;
    m_bus = 1'b1;
  endtask
  task automatic instr(logic [6:0] op, int fw, int mw, output bit trapped);
    bit to;
    bit lw = op == OP_LW;
    bit sw = op == OP_SW;
    bit r = op == OP_R;
    bit ok = lw || sw || r || op == OP_I;
    logic [1:0] aop = (lw || sw) ? ALU_ADD : ALU_FUNCT;
    trapped = 1'b1;
    access("fetch", fw, mk(0, 0, 1, 0, 0, 0, 2'b00, 0, 0), mk(1, 1, 1, 0, 0, 0, 2'b00, 0, 0), to);
    if (to) return;
    cyc("decode", op, 1'($urandom), mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    if (!ok) begin
      m_ill = 1'b1;
      return;
    end
    cyc("execute", rop(), 1'($urandom), mk(0, 0, 0, 0, 0, !r, aop, 0, 0));
    if (lw || sw) begin
      access("mem", mw, mk(0, 0, lw, sw, 1, 1, ALU_ADD, 0, 0), mk(0, 0, lw, sw, 1, 1, ALU_ADD, 0, 0), to);
      if (to) return;
      if (sw) begin
        m_ret = (m_ret + 1) % 16;
        trapped = 1'b0;
        return;
      end
    end
    cyc("wb", rop(), 1'($urandom), mk(0, 0, 0, 0, 0, 0, 2'b00, 1, lw));
    m_ret = (m_ret + 1) % 16;
    trapped = 1'b0;
  endtask
  function automatic int rwait();
    int r = $urandom_range(0, 19);
    return r == 0 ? TO + 1 : (r == 1 ? TO : $urandom_range(0, 2));
  endfunction
  initial begin : main
    bit t;
    int sel;
    logic [6:0] op;
    @(posedge clk);
    #1;
    do_reset(2);
    instr(OP_R, 0, 0, t);
    instr(OP_LW, 0, 2, t);
    instr(OP_SW, 0, 0, t);
    instr(OP_I, 1, 0, t);
    cyc("fetch", rop(), 1'b0, mk(0, 0, 1, 0, 0, 0, 2'b00, 0, 0));
    cyc("fetch", rop(), 1'b0, mk(0, 0, 1, 0, 0, 0, 2'b00, 0, 0));
    do_reset(1);
    instr(7'b1101111, 0, 0, t);
    trap_idle(50);
    do_reset(1);
    instr(OP_R, TO + 1, 0, t);
    trap_idle(3);
    do_reset(1);
    instr(OP_R, TO, 0, t);
    instr(OP_LW, 0, TO, t);
    instr(OP_SW, 0, TO + 1, t);
    trap_idle(3);
    do_reset(1);
    repeat (17) instr(OP_I, 0, 0, t);
    for (int k = 0; k < 300; k++) begin
      sel = $urandom_range(0, 19);
      if (sel == 19) begin
        op = rop();
        while (op inside {OP_R, OP_I, OP_LW, OP_SW}) op = rop();
      end else op = legal_ops[sel % 4];
      instr(op, rwait(), rwait(), t);
      if (t) begin
        trap_idle($urandom_range(1, 4));
        do_reset($urandom_range(1, 2));
      end
    end
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
